// File: rtl/alu_pkg.sv
// Shared ALU definitions: data widths, opcode values and the bridge FSM state encoding.
package alu_pkg;

    localparam int NB_DATA     = 8;
    localparam int NB_OP       = 6;
    localparam int NB_DATA_OUT = 9;

    localparam logic [NB_OP-1:0] ADD = 6'b100000;
    localparam logic [NB_OP-1:0] SUB = 6'b100010;
    localparam logic [NB_OP-1:0] AND = 6'b100100;
    localparam logic [NB_OP-1:0] OR  = 6'b100101;
    localparam logic [NB_OP-1:0] XOR = 6'b100110;
    localparam logic [NB_OP-1:0] SRA = 6'b000011;
    localparam logic [NB_OP-1:0] SRL = 6'b000010;
    localparam logic [NB_OP-1:0] NOR = 6'b100111;

    // Ordered so that every state from EVAL upward is a busy state.
    localparam logic [2:0] WAIT_A  = 3'd0;
    localparam logic [2:0] WAIT_B  = 3'd1;
    localparam logic [2:0] WAIT_OP = 3'd2;
    localparam logic [2:0] EVAL    = 3'd3;
    localparam logic [2:0] SEND_LO = 3'd4;
    localparam logic [2:0] WAIT_LO = 3'd5;
    localparam logic [2:0] SEND_HI = 3'd6;
    localparam logic [2:0] WAIT_HI = 3'd7;

endpackage

// File: rtl/alu_uart_bridge.sv
// Collects A, B and the opcode from the UART receiver, holds them for the ALU and
// returns the 9-bit result to the UART transmitter as two bytes, low byte first.
//
// state   | meaning
// WAIT_A  | idle, next rx byte is operand A
// WAIT_B  | next rx byte is operand B
// WAIT_OP | next rx byte is the opcode
// EVAL    | ALU inputs settled, capture result, launch low byte
// SEND_LO | low byte start pulse is on the output
// WAIT_LO | waiting for low byte to finish, then launch high byte
// SEND_HI | high byte start pulse is on the output
// WAIT_HI | waiting for high byte to finish
module alu_uart_bridge
    import alu_pkg::*;
#(
    parameter int NB_DATA     = alu_pkg::NB_DATA,
    parameter int NB_OP       = alu_pkg::NB_OP,
    parameter int NB_DATA_OUT = alu_pkg::NB_DATA_OUT
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NB_DATA-1:0]     i_rx_data,
    input  logic                   i_rx_done,
    output logic [NB_DATA-1:0]     o_data_a,
    output logic [NB_DATA-1:0]     o_data_b,
    output logic [NB_OP-1:0]       o_code,
    input  logic [NB_DATA_OUT-1:0] i_alu_result,
    output logic [NB_DATA-1:0]     o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_rx_drop,
    output logic                   o_busy
);

    logic [2:0]             state;
    logic [NB_DATA_OUT-1:0] result;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= WAIT_A;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_code     <= '0;
            result     <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_rx_drop  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_rx_drop  <= 1'b0;
            case (state)
                WAIT_A: if (i_rx_done) begin
                    o_data_a <= i_rx_data;
                    state    <= WAIT_B;
                end
                WAIT_B: if (i_rx_done) begin
                    o_data_b <= i_rx_data;
                    state    <= WAIT_OP;
                end
                WAIT_OP: if (i_rx_done) begin
                    o_code <= i_rx_data[NB_OP-1:0];
                    o_busy <= 1'b1;
                    state  <= EVAL;
                end
                // The low byte is launched straight from the ALU output so the
                // start pulse coincides with entry to SEND_LO.
                EVAL: begin
                    result     <= i_alu_result;
                    o_tx_data  <= i_alu_result[NB_DATA-1:0];
                    o_tx_start <= 1'b1;
                    state      <= SEND_LO;
                end
                SEND_LO: state <= WAIT_LO;
                WAIT_LO: if (i_tx_done) begin
                    o_tx_data  <= {{(NB_DATA-1){1'b0}}, result[NB_DATA_OUT-1]};
                    o_tx_start <= 1'b1;
                    state      <= SEND_HI;
                end
                SEND_HI: state <= WAIT_HI;
                WAIT_HI: if (i_tx_done) begin
                    o_busy <= 1'b0;
                    state  <= WAIT_A;
                end
                default: state <= WAIT_A;
            endcase
            if (i_rx_done && state >= EVAL)
                o_rx_drop <= 1'b1;
        end
    end

endmodule
